// File: rtl/gpio_regs_pkg.sv
// Shared register map, response code and write-channel state encoding for the
// AXI4-Lite GPIO responder.
package gpio_regs_pkg;

  localparam logic [3:0] LED_OFS    = 4'h0;
  localparam logic [3:0] BTN_OFS    = 4'h4;
  localparam logic [3:0] EDGE_OFS   = 4'h8;
  localparam logic [3:0] IRQ_EN_OFS = 4'hC;

  localparam logic [1:0] LED_IDX    = LED_OFS[3:2];
  localparam logic [1:0] BTN_IDX    = BTN_OFS[3:2];
  localparam logic [1:0] EDGE_IDX   = EDGE_OFS[3:2];
  localparam logic [1:0] IRQ_EN_IDX = IRQ_EN_OFS[3:2];

  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } wr_state_e;

  // Word index of a byte address; the low two address bits are ignored.
  function automatic logic [1:0] reg_idx(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer with rising-edge detect; edges are masked until the
// chain has settled after reset so buttons held at reset stay quiet.
module btn_sync_edge #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn,
  output logic [W-1:0] btn_level,
  output logic [W-1:0] rise
);

  localparam int CNT_MAX_C = SYNC_STAGES + 1;
  localparam int CNT_W_C   = $clog2(CNT_MAX_C + 1);

  logic [SYNC_STAGES-1:0][W-1:0] chain_r;
  logic [W-1:0]                  prev_r;
  logic [CNT_W_C-1:0]            cnt_r;
  logic                          armed_s;

  assign armed_s   = (cnt_r == CNT_W_C'(CNT_MAX_C));
  assign btn_level = chain_r[SYNC_STAGES-1];
  assign rise      = btn_level & ~prev_r & {W{armed_s}};

  // Synchronizer chain, delayed copy and saturating startup counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
      prev_r  <= '0;
      cnt_r   <= '0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], btn};
      prev_r  <= chain_r[SYNC_STAGES-1];
      if (!armed_s) begin
        cnt_r <= cnt_r + CNT_W_C'(1);
      end
    end
  end

endmodule

// File: rtl/axi_lite_gpio_responder.sv
// AXI4-Lite register slave driving LEDs, latching button rising edges in a
// W1C register and raising a level interrupt for enabled edges.
module axi_lite_gpio_responder
  import gpio_regs_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int LED_W       = 4,
  parameter int BTN_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [BTN_W-1:0]  btn,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  localparam int DW_C = (LED_W > BTN_W) ? LED_W : BTN_W;

  wr_state_e         state_r, state_next_s;
  logic [1:0]        awidx_r;
  logic [DW_C-1:0]   wdata_r;
  logic              wstrb0_r;
  logic [LED_W-1:0]  led_r;
  logic [BTN_W-1:0]  edge_r, irq_en_r, edge_clr_s;
  logic              irq_r, rvalid_r;
  logic [31:0]       rdata_r, rdata_next_s;
  logic [BTN_W-1:0]  btn_level_s, rise_s;
  logic              aw_hs_s, w_hs_s, ar_hs_s, commit_s, cstrb_s;
  logic [1:0]        cidx_s;
  logic [DW_C-1:0]   cdata_s;
  logic              unused_s;

  btn_sync_edge #(.W(BTN_W), .SYNC_STAGES(SYNC_STAGES)) u_btn (
    .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .btn(btn),
    .btn_level(btn_level_s), .rise(rise_s)
  );

  assign aw_hs_s  = s_axi_awvalid & s_axi_awready;
  assign w_hs_s   = s_axi_wvalid & s_axi_wready;
  assign ar_hs_s  = s_axi_arvalid & s_axi_arready;
  // A commit needs both halves, either already held or arriving this cycle.
  assign commit_s = ((state_r == HAVE_AW) | aw_hs_s) & ((state_r == HAVE_W) | w_hs_s);
  assign cidx_s   = (state_r == HAVE_AW) ? awidx_r : reg_idx(s_axi_awaddr[3:0]);
  assign cdata_s  = (state_r == HAVE_W) ? wdata_r : s_axi_wdata[DW_C-1:0];
  assign cstrb_s  = (state_r == HAVE_W) ? wstrb0_r : s_axi_wstrb[0];
  assign unused_s = ^{s_axi_wdata, s_axi_wstrb, s_axi_awaddr, s_axi_araddr};

  // Write-channel state register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_r <= IDLE;
    else                state_r <= state_next_s;
  end

  // Write-channel next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s && w_hs_s) state_next_s = RESP;
        else if (aw_hs_s)      state_next_s = HAVE_AW;
        else if (w_hs_s)       state_next_s = HAVE_W;
        else                   state_next_s = IDLE;
      end
      HAVE_AW: state_next_s = w_hs_s ? RESP : HAVE_AW;
      HAVE_W:  state_next_s = aw_hs_s ? RESP : HAVE_W;
      RESP:    state_next_s = s_axi_bready ? IDLE : RESP;
      default: state_next_s = IDLE;
    endcase
  end

  // Write-channel handshake outputs decoded from the state register.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (state_r)
      IDLE:    begin s_axi_awready = 1'b1; s_axi_wready = 1'b1; end
      HAVE_AW: s_axi_wready  = 1'b1;
      HAVE_W:  s_axi_awready = 1'b1;
      RESP:    s_axi_bvalid  = 1'b1;
      default: s_axi_bvalid  = 1'b0;
    endcase
  end

  // One-entry AW and W holding registers, emptied on commit.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awidx_r  <= 2'd0;
      wdata_r  <= '0;
      wstrb0_r <= 1'b0;
    end else if (commit_s) begin
      awidx_r  <= 2'd0;
      wdata_r  <= '0;
      wstrb0_r <= 1'b0;
    end else begin
      if (aw_hs_s) awidx_r <= reg_idx(s_axi_awaddr[3:0]);
      if (w_hs_s) begin
        wdata_r  <= s_axi_wdata[DW_C-1:0];
        wstrb0_r <= s_axi_wstrb[0];
      end
    end
  end

  // EDGE bits cleared by a W1C commit.
  always_comb begin
    if (commit_s && cstrb_s && (cidx_s == EDGE_IDX)) edge_clr_s = cdata_s[BTN_W-1:0];
    else                                              edge_clr_s = '0;
  end

  // Register file and interrupt; a hardware rise overrides a same-cycle clear.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      led_r    <= '0;
      irq_en_r <= '0;
      edge_r   <= '0;
      irq_r    <= 1'b0;
    end else begin
      if (commit_s && cstrb_s && (cidx_s == LED_IDX))    led_r    <= cdata_s[LED_W-1:0];
      if (commit_s && cstrb_s && (cidx_s == IRQ_EN_IDX)) irq_en_r <= cdata_s[BTN_W-1:0];
      edge_r <= (edge_r & ~edge_clr_s) | rise_s;
      irq_r  <= |(edge_r & irq_en_r);
    end
  end

  // Read mux; unused bits stay zero.
  always_comb begin
    rdata_next_s = 32'h0;
    case (reg_idx(s_axi_araddr[3:0]))
      LED_IDX:    rdata_next_s[LED_W-1:0] = led_r;
      BTN_IDX:    rdata_next_s[BTN_W-1:0] = btn_level_s;
      EDGE_IDX:   rdata_next_s[BTN_W-1:0] = edge_r;
      IRQ_EN_IDX: rdata_next_s[BTN_W-1:0] = irq_en_r;
      default:    rdata_next_s = 32'h0;
    endcase
  end

  // Read data channel, one-cycle latency, held until rready.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rdata_next_s;
    end else if (rvalid_r && s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

  assign s_axi_arready = ~rvalid_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_bresp   = RESP_OKAY;
  assign led           = led_r;
  assign irq           = irq_r;

endmodule

// File: tb/tb_axi_lite_gpio_responder.sv
// Directed bench for the AXI4-Lite GPIO responder; read data is checked
// against a queue of expected values filled when each read is issued.
module tb_axi_lite_gpio_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [3:0]  btn, led;
  logic        irq;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [31:0] exp_q[$];

  axi_lite_gpio_responder dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .btn(btn), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic rd_check(input string tag);
    logic [31:0] e;
    check({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, rdata, e);
      check({tag, "_rresp"}, 32'(rresp), 32'd0);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("b_valid", 32'(bvalid), 32'd1);
    check("b_resp", 32'(bresp), 32'd0);
    tick();
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    rd_check(tag);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; btn = 4'hF;
    awaddr = 4'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    araddr = 4'h0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // Reset state with buttons held down through reset.
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    axi_read(4'h8, 32'h0, "edge_rst");
    axi_read(4'h4, 32'hF, "btn_rst");
    btn = 4'h0;
    repeat (4) tick();

    // Same-cycle AW+W to LED, then readback; upper data bits and addr[1:0] ignored.
    axi_write(4'h0, 32'h5, 4'h1);
    check("led_5", 32'(led), 32'h5);
    axi_read(4'h0, 32'h5, "led_rd");
    axi_write(4'h3, 32'hFFFF_FFF9, 4'h1);
    check("led_9", 32'(led), 32'h9);
    axi_read(4'h0, 32'h9, "led_mask");

    // W three cycles ahead of AW, B held back four cycles with a second write pending.
    wdata = 32'hA; wstrb = 4'h1; wvalid = 1'b1; bready = 1'b0;
    tick();
    wvalid = 1'b0;
    check("w_held_wready", 32'(wready), 32'd0);
    check("w_held_awready", 32'(awready), 32'd1);
    check("w_held_led", 32'(led), 32'h9);
    tick();
    tick();
    awaddr = 4'h0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("late_aw_bvalid", 32'(bvalid), 32'd1);
    check("late_aw_led", 32'(led), 32'hA);
    awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h3; wstrb = 4'h1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bhold_awready", 32'(awready), 32'd0);
      check("bhold_wready", 32'(wready), 32'd0);
      check("bhold_bvalid", 32'(bvalid), 32'd1);
      check("bhold_led", 32'(led), 32'hA);
    end
    bready = 1'b1;
    tick();
    check("b_done_bvalid", 32'(bvalid), 32'd0);
    check("b_done_led", 32'(led), 32'hA);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("second_bvalid", 32'(bvalid), 32'd1);
    check("second_led", 32'(led), 32'h3);
    tick();
    check("second_bdone", 32'(bvalid), 32'd0);

    // Edge on btn[1] with its interrupt enabled, then W1C clear.
    axi_write(4'hC, 32'h2, 4'h1);
    btn = 4'h2;
    tick();
    tick();
    tick();
    check("irq_early", 32'(irq), 32'd0);
    exp_q.push_back(32'h2);
    araddr = 4'h8; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check("irq_set", 32'(irq), 32'd1);
    check("edge_set_rvalid", 32'(rvalid), 32'd1);
    rd_check("edge_set");
    tick();
    awaddr = 4'h8; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("irq_lag", 32'(irq), 32'd1);
    tick();
    check("irq_clr", 32'(irq), 32'd0);

    // Rise of btn[0] in the same cycle as a W1C of EDGE[0]: set wins.
    btn = 4'h3;
    tick();
    tick();
    awaddr = 4'h8; wdata = 32'h1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("setwins_bvalid", 32'(bvalid), 32'd1);
    tick();
    axi_read(4'h8, 32'h1, "set_wins");
    check("setwins_irq", 32'(irq), 32'd0);
    axi_write(4'h8, 32'h1, 4'h1);
    axi_read(4'h8, 32'h0, "w1c");

    // Strobe-less write to IRQ_EN concurrent with a BTN read.
    awaddr = 4'hC; wdata = 32'hF; wstrb = 4'h0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    exp_q.push_back(32'h3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("par_bvalid", 32'(bvalid), 32'd1);
    check("par_bresp", 32'(bresp), 32'd0);
    check("par_rvalid", 32'(rvalid), 32'd1);
    rd_check("par_btn");
    rready = 1'b1;
    tick();
    check("par_rdone", 32'(rvalid), 32'd0);
    check("par_bstill", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    check("par_bdone", 32'(bvalid), 32'd0);
    axi_read(4'hC, 32'h2, "irq_en_keep");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_lite_gpio_responder.md
Name: axi_lite_gpio_responder

Overview:
- AXI4-Lite slave (responder) in PL, mastered by the PS7 M_AXI_GP0 port through the block-design interconnect.
- Drives the board LEDs from a software-written register.
- Samples push-buttons through a synchronizer and latches their rising edges in a W1C status register.
- Raises a level interrupt to the PS IRQ_F2P input.

Parameters:
- ADDR_W, 4, AXI address width (byte address; 4 word registers).
- LED_W, 4, LED output width (1..8).
- BTN_W, 4, button input width (1..8).
- SYNC_STAGES, 2, button synchronizer depth (>=2).

Ports:
- s_axi_aclk  in  1  sole clock (FCLK_CLK0 domain)
- s_axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response, always 2'b00
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response, always 2'b00
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- btn  in  BTN_W  asynchronous push-button inputs
- led  out  LED_W  LED drive, registered
- irq  out  1  level interrupt, registered

Behaviour:
- Clock and reset: one clock, s_axi_aclk; s_axi_aresetn is asynchronous, active-low.
- Reset values: all outputs 0; all registers 0; synchronizer flops 0; bvalid/rvalid 0; awready/wready/arready 1.
- Register map (addr[3:2]; addr[1:0] ignored):
  - 0x0 LED: RW, bits[LED_W-1:0].
  - 0x4 BTN: RO, synchronized button level.
  - 0x8 EDGE: W1C, latched rising edges.
  - 0xC IRQ_EN: RW, per-button interrupt enable.
  - Unused bits read 0.
- Write channel:
  - AW and W are accepted independently, each into a one-entry holding register.
  - awready is deasserted while AW is held or bvalid=1; wready likewise for W.
  - The register write commits in the first cycle both AW and W are held. bvalid rises the same cycle and the holding registers clear.
  - bvalid holds until bready; the next AW/W is accepted the cycle after the B handshake.
  - Same-cycle awvalid+wvalid with both ready: commit next cycle, bvalid next cycle.
  - Only wstrb[0] gates the write; wstrb[0]=0 leaves the register unchanged but still returns B.
  - Writes to BTN have no effect but still respond.
- Read channel:
  - arready = !rvalid.
  - On an AR handshake, rdata is registered and rvalid rises the next cycle (latency 1).
  - rvalid/rdata hold until rready.
  - Reads have no side effects; EDGE is not cleared by a read.
- Read/write concurrency: reads and writes run fully in parallel. A read in the same cycle as a commit to the same register returns the pre-write value.
- Button path:
  - SYNC_STAGES-flop synchronizer per bit, then a one-flop delayed copy.
  - rise = sync & ~prev.
  - EDGE[i] is set on rise[i] regardless of IRQ_EN.
- Startup masking:
  - A saturating startup counter holds edge detection disabled for SYNC_STAGES+1 cycles after reset deassertion.
  - Buttons held at reset therefore do not produce spurious edges.
- Simultaneous events: a hardware rise and a W1C of the same EDGE bit in one cycle leave the bit set (set wins).
- Interrupt:
  - irq is registered: irq <= |(EDGE & IRQ_EN).
  - irq asserts 1 cycle after the EDGE bit sets and deasserts 1 cycle after the clearing write commits.
- Reset mid-transaction: any in-flight AW/W/AR is dropped; bvalid/rvalid go to 0 immediately (asynchronous); no response is issued for dropped transactions.

Decomposition:
- Package gpio_regs_pkg:
  - Register offset localparams: LED_OFS=0x0, BTN_OFS=0x4, EDGE_OFS=0x8, IRQ_EN_OFS=0xC.
  - OKAY resp constant.
  - Enum for the write-side state: IDLE, HAVE_AW, HAVE_W, RESP.
- One sub-module, btn_sync_edge:
  - Holds the synchronizer, delay flop, startup mask and rise output.
  - Parameterized by width and SYNC_STAGES.

Test Plan:
- Reset with btn=4'hF, release, wait 10 cycles -> EDGE read returns 0x0, BTN read returns 0xF, irq=0, led=0.
- AW and W same cycle, addr 0x0, data 0x5, wstrb 0x1 -> bvalid next cycle, bresp=0, led=4'h5. Read 0x0 returns 0x5 with rvalid 1 cycle after AR.
- W sent 3 cycles before AW, bready held low 4 cycles -> single commit on AW arrival; bvalid held; awready/wready low until B handshake; second write rejected until then.
- IRQ_EN=0x2, btn[1] 0->1 -> EDGE=0x2 SYNC_STAGES+1 cycles later, irq=1 one cycle after that. Write 0x2 to 0x8 -> irq=0 one cycle after commit.
- btn[0] rises in the same cycle as a W1C of 0x1 to EDGE commits -> EDGE[0] remains 1.
- Write with wstrb=0x0 to 0xC, and read of 0x4 issued during the write -> IRQ_EN unchanged, B OKAY; read returns the current BTN level; channels complete independently.
